// File: rtl/sinalizador_sonoro.sv
// sinalizador_sonoro: debounced, cadenced buzzer driver for the headlight warning.
// Beeps N_BIPES times then mutes until the warning drops; a silence press mutes early.
module sinalizador_sonoro #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int T_LIGADO        = 8,
  parameter int T_DESLIGADO     = 8,
  parameter int N_BIPES         = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic sinalizador,
  input  logic silenciar,
  output logic buzina,
  output logic ativo,
  output logic silenciado
);

  localparam int DEB_MAX = (DEBOUNCE_CICLOS > 2) ? DEBOUNCE_CICLOS : 2;
  localparam int T_MAIOR = (T_LIGADO > T_DESLIGADO) ? T_LIGADO : T_DESLIGADO;
  localparam int TMR_MAX = (T_MAIOR > 2) ? T_MAIOR : 2;
  localparam int BIP_MAX = (N_BIPES > 2) ? N_BIPES : 2;
  localparam int CW = $clog2(DEB_MAX) + 1;
  localparam int TW = $clog2(TMR_MAX) + 1;
  localparam int BW = $clog2(BIP_MAX) + 1;

  localparam logic [CW-1:0] CNT_FIM     = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_UM      = CW'(1);
  localparam logic [TW-1:0] TMR_FIM_ON  = TW'(T_LIGADO - 1);
  localparam logic [TW-1:0] TMR_FIM_OFF = TW'(T_DESLIGADO - 1);
  localparam logic [TW-1:0] TMR_UM      = TW'(1);
  localparam logic [BW-1:0] BIP_FIM     = BW'(N_BIPES);
  localparam logic [BW-1:0] BIP_UM      = BW'(1);

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    CONFIRMA = 3'd1,
    BIPE_ON  = 3'd2,
    BIPE_OFF = 3'd3,
    SILENCIO = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] bip_q, bip_d;
  logic          sin_meta_q, sinc_q;
  logic          mute_meta_q, mute_s_q, mute_dly_q;
  logic          buzina_q, ativo_q, silenciado_q;
  logic          mute_p;

  assign mute_p     = mute_s_q & ~mute_dly_q;
  assign buzina     = buzina_q;
  assign ativo      = ativo_q;
  assign silenciado = silenciado_q;

  // Two-flop synchronizers for both async inputs, plus the silence edge-detect delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sin_meta_q  <= 1'b0;
      sinc_q      <= 1'b0;
      mute_meta_q <= 1'b0;
      mute_s_q    <= 1'b0;
      mute_dly_q  <= 1'b0;
    end else begin
      sin_meta_q  <= sinalizador;
      sinc_q      <= sin_meta_q;
      mute_meta_q <= silenciar;
      mute_s_q    <= mute_meta_q;
      mute_dly_q  <= mute_s_q;
    end
  end

  // Next-state logic; a dropped warning outranks a silence press while beeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    bip_d   = bip_q;
    case (state_q)
      ESPERA: begin
        if (sinc_q) begin
          state_d = CONFIRMA;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ESPERA;
        end
      end
      CONFIRMA: begin
        if (!sinc_q) begin
          state_d = ESPERA;
        end else if (cnt_q == CNT_FIM) begin
          state_d = BIPE_ON;
          tmr_d   = {TW{1'b0}};
          bip_d   = {BW{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end
      BIPE_ON: begin
        if (!sinc_q) begin
          state_d = ESPERA;
        end else if (mute_p) begin
          state_d = SILENCIO;
        end else if (tmr_q == TMR_FIM_ON) begin
          state_d = BIPE_OFF;
          tmr_d   = {TW{1'b0}};
          bip_d   = bip_q + BIP_UM;
        end else begin
          tmr_d = tmr_q + TMR_UM;
        end
      end
      BIPE_OFF: begin
        if (!sinc_q) begin
          state_d = ESPERA;
        end else if (mute_p) begin
          state_d = SILENCIO;
        end else if (tmr_q == TMR_FIM_OFF) begin
          if (bip_q == BIP_FIM) begin
            state_d = SILENCIO;
          end else begin
            state_d = BIPE_ON;
          end
          tmr_d = {TW{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_UM;
        end
      end
      SILENCIO: begin
        if (!sinc_q) begin
          state_d = ESPERA;
        end else begin
          state_d = SILENCIO;
        end
      end
      default: begin
        state_d = ESPERA;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so they track it exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ESPERA;
      cnt_q        <= {CW{1'b0}};
      tmr_q        <= {TW{1'b0}};
      bip_q        <= {BW{1'b0}};
      buzina_q     <= 1'b0;
      ativo_q      <= 1'b0;
      silenciado_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      bip_q        <= bip_d;
      buzina_q     <= (state_d == BIPE_ON);
      ativo_q      <= (state_d == BIPE_ON) || (state_d == BIPE_OFF);
      silenciado_q <= (state_d == SILENCIO);
    end
  end

endmodule

// File: tb/tb_sinalizador_sonoro.sv
// Bench for sinalizador_sonoro: directed scenarios plus random stimulus,
// checked every cycle against a phase/elapsed-time model of the beep cadence.
module tb_sinalizador_sonoro;

  localparam int DEB = 4;
  localparam int TL  = 8;
  localparam int TD  = 8;
  localparam int NB  = 5;
  localparam int PER = TL + TD;

  localparam int M_IDLE = 0;
  localparam int M_DEB  = 1;
  localparam int M_BEEP = 2;
  localparam int M_MUTE = 3;

  logic clock = 1'b0;
  logic reset, sinalizador, silenciar;
  logic buzina, ativo, silenciado;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   chk_en  = 1'b0;

  int   mode, run, el;
  bit   s1, s2, m1, m2, m3;
  logic exp_buz, exp_atv, exp_sil;

  sinalizador_sonoro #(
    .DEBOUNCE_CICLOS(DEB),
    .T_LIGADO(TL),
    .T_DESLIGADO(TD),
    .N_BIPES(NB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sinalizador(sinalizador),
    .silenciar(silenciar),
    .buzina(buzina),
    .ativo(ativo),
    .silenciado(silenciado)
  );

  always #5 clock = ~clock;

  task automatic update_exp();
    exp_atv = (mode == M_BEEP);
    exp_buz = (mode == M_BEEP) && ((el % PER) < TL);
    exp_sil = (mode == M_MUTE);
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    run  = 0;
    el   = 0;
    s1 = 1'b0; s2 = 1'b0;
    m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
    update_exp();
  endtask

  // One rising edge: the warning is seen two edges late, a silence press
  // counts only on its synced rising edge, buzzer phase follows elapsed time.
  task automatic model_step();
    bit sinc, mp;
    if (reset) begin
      model_reset();
    end else begin
      sinc = s2;
      mp   = m2 & ~m3;
      if (mode == M_IDLE) begin
        if (sinc) begin mode = M_DEB; run = 1; end
      end else if (mode == M_DEB) begin
        if (!sinc) mode = M_IDLE;
        else begin
          run++;
          if (run == DEB + 1) begin mode = M_BEEP; el = 0; end
        end
      end else if (mode == M_BEEP) begin
        if (!sinc) mode = M_IDLE;
        else if (mp) mode = M_MUTE;
        else begin
          el++;
          if (el == NB * PER) mode = M_MUTE;
        end
      end else begin
        if (!sinc) mode = M_IDLE;
      end
      s2 = s1; s1 = sinalizador;
      m3 = m2; m2 = m1; m1 = silenciar;
      update_exp();
    end
  endtask

  task automatic check(input string nm, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      model_step();
      @(negedge clock);
    end
  endtask

  task automatic restart();
    #2 reset = 1'b1;
    model_reset();
    sinalizador = 1'b0;
    silenciar   = 1'b0;
    cycles(2);
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("buzina", buzina, exp_buz);
      check("ativo", ativo, exp_atv);
      check("silenciado", silenciado, exp_sil);
    end
  end

  initial begin
    int len;
    reset = 1'b1;
    sinalizador = 1'b0;
    silenciar = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cycles(3);
    check("pin_reset_buz", buzina, 1'b0);
    check("pin_reset_sil", silenciado, 1'b0);
    reset = 1'b0;

    // Held warning: beeps on edges 7..14, 23..30, ...; mute from edge 87.
    restart();
    sinalizador = 1'b1;
    cycles(6);  check("pin_e6_buz", buzina, 1'b0);
    cycles(1);  check("pin_e7_buz", buzina, 1'b1); check("pin_e7_atv", ativo, 1'b1);
    cycles(7);  check("pin_e14_buz", buzina, 1'b1);
    cycles(1);  check("pin_e15_buz", buzina, 1'b0);
    cycles(8);  check("pin_e23_buz", buzina, 1'b1);
    cycles(63); check("pin_e86_sil", silenciado, 1'b0); check("pin_e86_atv", ativo, 1'b1);
    cycles(1);  check("pin_e87_sil", silenciado, 1'b1); check("pin_e87_atv", ativo, 1'b0);
    cycles(30); check("pin_mute_hold_buz", buzina, 1'b0);

    // Silence press during the second beep, then re-arm with a one-cycle drop.
    restart();
    sinalizador = 1'b1;
    cycles(25);
    silenciar = 1'b1;
    cycles(1);
    silenciar = 1'b0;
    cycles(2);  check("pin_mute_sil", silenciado, 1'b1); check("pin_mute_buz", buzina, 1'b0);
    cycles(10); check("pin_mute_hold", silenciado, 1'b1);
    sinalizador = 1'b0;
    cycles(1);
    sinalizador = 1'b1;
    cycles(2);  check("pin_rearm_sil", silenciado, 1'b0);
    cycles(4);  check("pin_rearm_d6", buzina, 1'b0);
    cycles(1);  check("pin_rearm_d7", buzina, 1'b1);
    cycles(80); check("pin_rearm_mute", silenciado, 1'b1);

    // Warning drop and silence press in the same cycle: drop wins.
    restart();
    sinalizador = 1'b1;
    cycles(10);
    sinalizador = 1'b0;
    silenciar = 1'b1;
    cycles(5);  check("pin_simul_sil", silenciado, 1'b0); check("pin_simul_atv", ativo, 1'b0);
    silenciar = 1'b0;
    cycles(3);

    // Glitch shorter than the debounce.
    sinalizador = 1'b1;
    cycles(3);
    sinalizador = 1'b0;
    cycles(15); check("pin_glitch_atv", ativo, 1'b0);

    // Asynchronous reset in the middle of a beep.
    restart();
    sinalizador = 1'b1;
    cycles(9);  check("pin_pre_rst_buz", buzina, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("pin_async_buz", buzina, 1'b0);
    check("pin_async_atv", ativo, 1'b0);
    check("pin_async_sil", silenciado, 1'b0);
    cycles(2);
    reset = 1'b0;
    cycles(6);  check("pin_postrst_e6", buzina, 1'b0);
    cycles(1);  check("pin_postrst_e7", buzina, 1'b1);
    cycles(10);

    // Random segments of held warning levels, sparse silence presses and resets.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 14) == 0) restart();
      sinalizador = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 110);
      for (int c = 0; c < len; c++) begin
        silenciar = ($urandom_range(0, 24) == 0);
        cycles(1);
      end
    end
    silenciar = 1'b0;
    cycles(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
